// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the main-RAM arbiter.
// Contents:
//   arb_state_e  access sequencer states (2-bit encoding)
//   OwnCpu/OwnIo owner codes, also used for the last-owner record
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } arb_state_e;

    localparam logic OwnCpu = 1'b0;
    localparam logic OwnIo  = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick (combinational).
// Ports:
//   req        in   {io,cpu} request lines
//   last_owner in   owner of the most recently completed access
//   pick       out  one-hot {io,cpu} winner, 00 when nobody requests
module mem_arbiter_rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic [1:0] pick
);

    always_comb begin
        pick = req;
        // On a tie the side that did not go last wins.
        if (req == 2'b11) begin
            pick = (last_owner == OwnCpu) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port main RAM between the CPU and the I/O port.
// Each access runs IDLE -> ISSUE -> WAIT (RAM_LAT cycles) -> RESP -> IDLE.
// Ports:
//   Clock, Reset_n              clock, synchronous active-low reset
//   cpu_req/we/addr/wdata       CPU request, held until cpu_done
//   cpu_done                    one-cycle CPU completion pulse
//   io_req/we/addr/wdata        I/O request, held until io_done
//   io_done                     one-cycle I/O completion pulse
//   rdata                       last read word, shared by both requesters
//   grant                       one-hot owner {io,cpu}, 00 when idle
//   busy                        high whenever not idle
//   ram_addr/ram_wdata          latched RAM address and write data
//   ram_re/ram_we               one-cycle RAM strobes
//   ram_rdata                   RAM read data, valid RAM_LAT cycles after ram_re
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_done,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_done,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        grant,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_re,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [2:0] LatCnt = 3'(RAM_LAT);

    arb_state_e        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [1:0]        grant_q, grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              last_owner_q, last_owner_d;
    logic [1:0]        pick;

    mem_arbiter_rr_pick2 u_pick (
        .req        ({io_req, cpu_req}),
        .last_owner (last_owner_q),
        .pick       (pick)
    );

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            grant_q      <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            last_owner_q <= OwnIo;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        last_owner_d = last_owner_q;

        unique case (state_q)
            StIdle: begin
                if (pick != 2'b00) begin
                    grant_d = pick;
                    we_d    = pick[1] ? io_we    : cpu_we;
                    addr_d  = pick[1] ? io_addr  : cpu_addr;
                    wdata_d = pick[1] ? io_wdata : cpu_wdata;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = LatCnt;
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q <= 3'd1) begin
                    // Writes leave the last read value in place.
                    if (!we_q) begin
                        rdata_d = ram_rdata;
                    end
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StResp: begin
                last_owner_d = grant_q[1] ? OwnIo : OwnCpu;
                grant_d      = 2'b00;
                state_d      = StIdle;
            end
        endcase
    end

    assign busy      = (state_q != StIdle);
    assign grant     = grant_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_re    = (state_q == StIssue) && !we_q;
    assign ram_we    = (state_q == StIssue) && we_q;
    assign cpu_done  = (state_q == StResp) && grant_q[0];
    assign io_done   = (state_q == StResp) && grant_q[1];
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        cpu_req, cpu_we, io_req, io_we, cpu_req3;
    logic        io_req3 = 1'b0;
    logic [8:0]  cpu_addr, io_addr;
    logic [31:0] cpu_wdata, io_wdata;

    logic        cpu_done1, io_done1, busy1, ram_re1, ram_we1;
    logic [1:0]  grant1;
    logic [8:0]  ram_addr1;
    logic [31:0] rdata1, ram_wdata1, ram_rdata1;

    logic        cpu_done3, io_done3, busy3, ram_re3, ram_we3;
    logic [1:0]  grant3;
    logic [8:0]  ram_addr3;
    logic [31:0] rdata3, ram_wdata3, ram_rdata3;

    int errors = 0;
    int checks = 0;
    int cpu_dn = 0;
    int io_dn  = 0;
    int cpu_base, io_base;

    always #5 Clock = ~Clock;

    mem_arbiter #(.ADDR_W(9), .DATA_W(32), .RAM_LAT(1)) u_dut1 (
        .Clock(Clock), .Reset_n(Reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_done(cpu_done1),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_done(io_done1),
        .rdata(rdata1), .grant(grant1), .busy(busy1),
        .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_re(ram_re1), .ram_we(ram_we1),
        .ram_rdata(ram_rdata1)
    );

    mem_arbiter #(.ADDR_W(9), .DATA_W(32), .RAM_LAT(3)) u_dut3 (
        .Clock(Clock), .Reset_n(Reset_n),
        .cpu_req(cpu_req3), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_done(cpu_done3),
        .io_req(io_req3), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_done(io_done3),
        .rdata(rdata3), .grant(grant3), .busy(busy3),
        .ram_addr(ram_addr3), .ram_wdata(ram_wdata3), .ram_re(ram_re3), .ram_we(ram_we3),
        .ram_rdata(ram_rdata3)
    );

    // RAM model: data is presented only in the cycle exactly RAM_LAT cycles after
    // the read strobe; every other cycle shows a marker value.
    logic [31:0] mem [512] = '{9'h01F: 32'hDEADBEEF, default: 32'h0};
    logic        v1 = 1'b0;
    logic [31:0] d1 = 32'h0;
    logic [2:0]  v3 = 3'b000;
    logic [31:0] d3 [3] = '{default: 32'h0};

    always @(posedge Clock) begin
        if (ram_we1) mem[ram_addr1] <= ram_wdata1;
        v1    <= ram_re1;
        d1    <= mem[ram_addr1];
        v3    <= {v3[1:0], ram_re3};
        d3[0] <= mem[ram_addr3];
        d3[1] <= d3[0];
        d3[2] <= d3[1];
        if (cpu_done1) cpu_dn <= cpu_dn + 1;
        if (io_done1)  io_dn  <= io_dn + 1;
    end

    assign ram_rdata1 = v1    ? d1    : 32'h0BAD0BAD;
    assign ram_rdata3 = v3[2] ? d3[2] : 32'h0BAD0BAD;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // {grant, busy, cpu_done, io_done, ram_re, ram_we}
    function automatic logic [31:0] ctl1();
        return {24'h0, grant1, busy1, cpu_done1, io_done1, ram_re1, ram_we1};
    endfunction

    initial begin
        Reset_n = 1'b0; cpu_req = 1'b1; io_req = 1'b1; cpu_req3 = 1'b0;
        cpu_we = 1'b0; io_we = 1'b0; cpu_addr = 9'h000; io_addr = 9'h000;
        cpu_wdata = 32'h0; io_wdata = 32'h0;

        // 1: reset with both requests pending
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_ctl", ctl1(), 32'h0);
            chk("rst_addr", {23'h0, ram_addr1}, 32'h0);
            chk("rst_wdata", ram_wdata1, 32'h0);
            chk("rst_rdata", rdata1, 32'h0);
        end
        Reset_n = 1'b1;                                   // cycle t (IDLE)
        step();                                           // t+1
        chk("rst_first_grant", {30'h0, grant1}, 32'h1);
        chk("rst_first_re", {31'h0, ram_re1}, 32'h1);
        cpu_req = 1'b0; io_req = 1'b0;
        step();                                           // t+2
        step();                                           // t+3
        chk("rst_first_done", ctl1(), 32'b01_1_10_00);
        step();                                           // idle
        chk("rst_idle", ctl1(), 32'h0);

        // 2: CPU read of 0x01F
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h01F;
        step();
        chk("rd_issue", ctl1(), 32'b01_1_00_10);
        chk("rd_addr", {23'h0, ram_addr1}, 32'h01F);
        cpu_addr = 9'h155;
        step();
        chk("rd_wait", ctl1(), 32'b01_1_00_00);
        chk("rd_rdata_old", rdata1, 32'h0);
        step();
        chk("rd_done", ctl1(), 32'b01_1_10_00);
        chk("rd_rdata", rdata1, 32'hDEADBEEF);
        cpu_req = 1'b0;
        step();
        chk("rd_idle", ctl1(), 32'h0);

        // 3: I/O write 0x12345678 to 0x100
        io_req = 1'b1; io_we = 1'b1; io_addr = 9'h100; io_wdata = 32'h12345678;
        step();
        chk("wr_issue", ctl1(), 32'b10_1_00_01);
        chk("wr_addr", {23'h0, ram_addr1}, 32'h100);
        chk("wr_wdata", ram_wdata1, 32'h12345678);
        io_addr = 9'h0AA; io_wdata = 32'hFFFF0000; io_we = 1'b0;
        step();
        chk("wr_wait", ctl1(), 32'b10_1_00_00);
        chk("wr_addr_held", {23'h0, ram_addr1}, 32'h100);
        chk("wr_wdata_held", ram_wdata1, 32'h12345678);
        step();
        chk("wr_done", ctl1(), 32'b10_1_01_00);
        chk("wr_rdata_kept", rdata1, 32'hDEADBEEF);
        io_req = 1'b0;
        step();
        chk("wr_idle", ctl1(), 32'h0);

        // 4: contention, both held for four accesses
        cpu_base = cpu_dn; io_base = io_dn;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h01F;
        io_req  = 1'b1; io_we  = 1'b0; io_addr  = 9'h100;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_issue", ctl1(), (k % 2 == 0) ? 32'b01_1_00_10 : 32'b10_1_00_10);
            step();
            chk("rr_wait", {30'h0, cpu_done1, io_done1}, 32'h0);
            step();
            chk("rr_done", ctl1(), (k % 2 == 0) ? 32'b01_1_10_00 : 32'b10_1_01_00);
            chk("rr_rdata", rdata1, (k % 2 == 0) ? 32'hDEADBEEF : 32'h12345678);
            if (k == 3) begin
                cpu_req = 1'b0; io_req = 1'b0;
            end
            step();
            chk("rr_idle", ctl1(), 32'h0);
        end
        chk("rr_cpu_count", cpu_dn - cpu_base, 32'd2);
        chk("rr_io_count", io_dn - io_base, 32'd2);

        // 5a: request withdrawn during WAIT
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h01F;
        step();
        chk("wd_issue", ctl1(), 32'b01_1_00_10);
        step();
        cpu_req = 1'b0;
        step();
        chk("wd_done", ctl1(), 32'b01_1_10_00);
        step();
        chk("wd_idle", ctl1(), 32'h0);

        // 5b: reset during WAIT
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h005; cpu_wdata = 32'h0000AAAA;
        step();
        chk("mr_issue", ctl1(), 32'b01_1_00_01);
        step();
        Reset_n = 1'b0; cpu_req = 1'b0;
        step();
        chk("mr_ctl", ctl1(), 32'h0);
        chk("mr_addr", {23'h0, ram_addr1}, 32'h0);
        chk("mr_rdata", rdata1, 32'h0);
        Reset_n = 1'b1;
        step();
        chk("mr_no_done", ctl1(), 32'h0);

        // 6: RAM_LAT=3 CPU read
        cpu_req3 = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h01F;
        step();                                           // t+1
        chk("l3_re", {31'h0, ram_re3}, 32'h1);
        chk("l3_addr", {23'h0, ram_addr3}, 32'h01F);
        cpu_req3 = 1'b0;
        step();                                           // t+2
        chk("l3_re_off", {31'h0, ram_re3}, 32'h0);
        step();                                           // t+3
        chk("l3_rdata_t3", rdata3, 32'h0);
        step();                                           // t+4
        chk("l3_rdata_t4", rdata3, 32'h0);
        chk("l3_no_done_t4", {31'h0, cpu_done3}, 32'h0);
        step();                                           // t+5
        chk("l3_done", {31'h0, cpu_done3}, 32'h1);
        chk("l3_rdata", rdata3, 32'hDEADBEEF);
        step();
        chk("l3_idle", {30'h0, busy3, cpu_done3}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
